// File: rtl/mips_debug_controller_if.sv
// UART FIFO side of the MIPS debug controller: RX pop port and TX push port.
// Handshake: a byte moves only in a cycle where rd=1 with rx_empty=0, or wr=1 with tx_full=0.
interface mips_debug_controller_if;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rd;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       wr;

  modport master (
    input  rx_data, rx_empty, tx_full,
    output rd, tx_data, wr
  );

  modport slave (
    output rx_data, rx_empty, tx_full,
    input  rd, tx_data, wr
  );
endinterface

// File: rtl/mips_debug_controller.sv
// Run/step/dump sequencer between the UART FIFOs and the MIPS pipeline.
// Optional feature: define AUTO_DUMP_EN to dump automatically after every step and after a run halts.
module mips_debug_controller #(
  parameter int         DEBUG_W  = 322,
  parameter int         CNT_W    = 32,
  parameter logic [7:0] CMD_RUN  = 8'h63,
  parameter logic [7:0] CMD_STEP = 8'h73,
  parameter logic [7:0] CMD_DUMP = 8'h64
) (
  input  logic                   clock,
  input  logic                   reset,
  mips_debug_controller_if.master uart,
  input  logic                   halt,
  input  logic [DEBUG_W-1:0]     debug_signal,
  output logic                   mips_enable,
  output logic                   halted,
  output logic                   busy,
  output logic [2:0]             state_o
);

  localparam int NB      = (DEBUG_W + 7) / 8;
  localparam int CNT_B   = CNT_W / 8;
  localparam int FRAME_B = CNT_B + NB;
  localparam int SR_W    = FRAME_B * 8;
  localparam int IDX_W   = $clog2(FRAME_B + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP      = 3'd2,
    S_DUMP_LOAD = 3'd3,
    S_DUMP_SEND = 3'd4
  } state_e;

`ifdef AUTO_DUMP_EN
  localparam state_e DONE_STATE = S_DUMP_LOAD;
`else
  localparam state_e DONE_STATE = S_IDLE;
`endif

  state_e             state_q, state_d;
  logic               en_q, en_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NB*8-1:0]    dbg_ext;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      sr_q     <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    en_d         = 1'b0;
    halted_d     = halted_q;
    cnt_d        = cnt_q + CNT_W'(en_q);
    sr_d         = sr_q;
    idx_d        = idx_q;
    uart.rd      = 1'b0;
    uart.wr      = 1'b0;
    uart.tx_data = 8'h00;
    dbg_ext      = '0;
    dbg_ext[DEBUG_W-1:0] = debug_signal;

    case (state_q)
      S_IDLE: begin
        // Reset gates the pop so an in-flight reset cycle never consumes a byte.
        if (!uart.rx_empty && !reset) begin
          uart.rd = 1'b1;
          if (uart.rx_data == CMD_RUN && !halted_q) begin
            state_d = S_RUN;
            en_d    = 1'b1;
          end else if (uart.rx_data == CMD_STEP && !halted_q) begin
            state_d = S_STEP;
            en_d    = 1'b1;
          end else if (uart.rx_data == CMD_DUMP) begin
            state_d = S_DUMP_LOAD;
          end
        end
      end
      S_RUN: begin
        if (halt) begin
          halted_d = 1'b1;
          state_d  = DONE_STATE;
        end else begin
          en_d = 1'b1;
        end
      end
      S_STEP: begin
        if (halt) halted_d = 1'b1;
        state_d = DONE_STATE;
      end
      S_DUMP_LOAD: begin
        sr_d    = {cnt_q, dbg_ext};
        idx_d   = '0;
        state_d = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        if (!uart.tx_full && !reset) begin
          uart.wr      = 1'b1;
          uart.tx_data = sr_q[SR_W-1 -: 8];
          sr_d         = sr_q << 8;
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(FRAME_B - 1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mips_enable = en_q;
  assign halted      = halted_q;
  assign busy        = (state_q != S_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_mips_debug_controller.sv
// Directed + randomized bench for mips_debug_controller with a byte-level frame model.
module tb_mips_debug_controller;
  localparam int DEBUG_W = 322;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               halt  = 1'b0;
  logic [DEBUG_W-1:0] dbg   = '0;
  logic               mips_enable, halted, busy;
  logic [2:0]         state_o;

  mips_debug_controller_if bus ();

  mips_debug_controller dut (
    .clock       (clock),
    .reset       (reset),
    .uart        (bus),
    .halt        (halt),
    .debug_signal(dbg),
    .mips_enable (mips_enable),
    .halted      (halted),
    .busy        (busy),
    .state_o     (state_o)
  );

  initial forever #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int tx_mode = 0;
  int cyc_n   = 0;
  int en_highs = 0;
  int en_rises = 0;
  int viol     = 0;
  logic en_prev = 1'b0;
  logic rd_s, wr_s, en_s, halted_s, busy_s;
  logic [7:0] tx_s;
  logic [31:0] m_cnt = 0;
  logic m_halted = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, sample at the falling edge, return #1 after the rising edge.
  task automatic cycle();
    bus.rx_empty = (rx_q.size() == 0);
    bus.rx_data  = bus.rx_empty ? 8'h00 : rx_q[0];
    case (tx_mode)
      1:       bus.tx_full = cyc_n[0];
      2:       bus.tx_full = ($urandom_range(0, 2) == 0);
      default: bus.tx_full = 1'b0;
    endcase
    @(negedge clock);
    rd_s = bus.rd; wr_s = bus.wr; tx_s = bus.tx_data;
    en_s = mips_enable; halted_s = halted; busy_s = busy;
    if (wr_s && bus.tx_full) viol++;
    if (wr_s && rd_s) viol++;
    if (wr_s) got_q.push_back(tx_s);
    if (rd_s) void'(rx_q.pop_front());
    if (en_s) en_highs++;
    if (en_s && !en_prev) en_rises++;
    en_prev = en_s;
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    int idle_run = 0;
    while (idle_run < 2 && n < budget) begin
      cycle();
      n++;
      if (!busy_s && !rd_s && rx_q.size() == 0) idle_run++;
      else idle_run = 0;
    end
    chk({tag, "_timeout"}, (n >= budget), 0);
  endtask

  function automatic void push_frame(input logic [31:0] cnt, input logic [DEBUG_W-1:0] d);
    logic [327:0] ext;
    ext = '0;
    ext[DEBUG_W-1:0] = d;
    for (int b = 3; b >= 0; b--) exp_q.push_back(cnt[b*8 +: 8]);
    for (int i = 40; i >= 0; i--) exp_q.push_back(ext[i*8 +: 8]);
  endfunction

  function automatic void model_step();
    if (!m_halted) begin
      m_cnt++;
      if (halt) m_halted = 1'b1;
`ifdef AUTO_DUMP_EN
      push_frame(m_cnt, dbg);
`endif
    end
  endfunction

  task automatic compare_frames(input string tag);
    int n;
    chk({tag, "_frame_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_frame_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [DEBUG_W-1:0] rand_dbg();
    logic [351:0] r;
    for (int i = 0; i < 11; i++) r[i*32 +: 32] = $urandom;
    return r[DEBUG_W-1:0];
  endfunction

  initial begin
    int n;
    int v0;
    int exp_en;
    int k;
    logic [7:0] junk;

    bus.rx_empty = 1'b1;
    bus.rx_data  = 8'h00;
    bus.tx_full  = 1'b0;
    @(posedge clock);
    #1;

    // T1: reset held 3 cycles, then an immediate dump of the zeroed state.
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    chk("rst_enable", en_s, 0);
    chk("rst_wr", wr_s, 0);
    chk("rst_rd", rd_s, 0);
    chk("rst_halted", halted_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_tx_data", tx_s, 0);
    rx_q.push_back(8'h64);
    push_frame(m_cnt, dbg);
    run_idle("t1", 500);
    compare_frames("t1");

    // T2: three steps then a dump.
    dbg = rand_dbg();
    en_highs = 0; en_rises = 0;
    repeat (3) begin rx_q.push_back(8'h73); model_step(); end
    rx_q.push_back(8'h64);
    push_frame(m_cnt, dbg);
    run_idle("t2", 1000);
    chk("t2_en_cycles", en_highs, 3);
    chk("t2_en_pulses", en_rises, 3);
    compare_frames("t2");

    // T3: run, halt after 100 enabled cycles, then run/step are ignored.
    dbg = rand_dbg();
    en_highs = 0;
    rx_q.push_back(8'h63);
    n = 0;
    while (en_highs < 100 && n < 500) begin cycle(); n++; end
    chk("t3_run_timeout", (n >= 500), 0);
    halt = 1'b1;
    cycle();
    chk("t3_en_at_halt", en_s, 1);
    cycle();
    chk("t3_en_fall", en_s, 0);
    chk("t3_halted", halted_s, 1);
    m_cnt = m_cnt + 101;
    m_halted = 1'b1;
`ifdef AUTO_DUMP_EN
    push_frame(m_cnt, dbg);
`endif
    en_highs = 0;
    rx_q.push_back(8'h63);
    rx_q.push_back(8'h73);
    run_idle("t3", 1000);
    chk("t3_ignored_en", en_highs, 0);
    chk("t3_halted_sticky", halted_s, 1);
    compare_frames("t3");

    // T4: patterned vector, TX FIFO full every other cycle.
    dbg = {2'b10, {40{8'hA5}}};
    tx_mode = 1;
    v0 = viol;
    rx_q.push_back(8'h64);
    push_frame(m_cnt, dbg);
    run_idle("t4", 1000);
    chk("t4_byte4", (got_q.size() > 4) ? got_q[4] : 8'hxx, 8'h02);
    chk("t4_wr_rules", viol - v0, 0);
    compare_frames("t4");
    tx_mode = 0;

    // T5: reset after byte 10 of a dump.
    dbg = rand_dbg();
    halt = 1'b0;
    rx_q.push_back(8'h64);
    n = 0;
    while (got_q.size() < 10 && n < 200) begin cycle(); n++; end
    chk("t5_dump_timeout", (n >= 200), 0);
    reset = 1'b1;
    cycle();
    chk("t5_wr_in_reset", wr_s, 0);
    reset = 1'b0;
    cycle();
    chk("t5_busy", busy_s, 0);
    chk("t5_enable", en_s, 0);
    chk("t5_halted", halted_s, 0);
    repeat (5) cycle();
    chk("t5_no_more_wr", got_q.size(), 10);
    got_q.delete();
    exp_q.delete();
    m_cnt = 0;
    m_halted = 1'b0;

    // T6: unknown byte discarded, following step still runs once.
    en_highs = 0;
    rx_q.push_back(8'h78);
    rx_q.push_back(8'h73);
    model_step();
    run_idle("t6", 500);
    chk("t6_en_cycles", en_highs, 1);
    compare_frames("t6");

    // Randomized commands with random back-pressure and occasional halt.
    tx_mode = 2;
    for (int it = 0; it < 24; it++) begin
      dbg = rand_dbg();
      halt = ($urandom_range(0, 7) == 0);
      en_highs = 0;
      exp_en = 0;
      k = $urandom_range(0, 2);
      if (k == 0) begin
        if (!m_halted) exp_en = 1;
        rx_q.push_back(8'h73);
        model_step();
      end else if (k == 1) begin
        rx_q.push_back(8'h64);
        push_frame(m_cnt, dbg);
      end else begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'h63 || junk == 8'h73 || junk == 8'h64) junk = 8'h00;
        rx_q.push_back(junk);
      end
      run_idle("rand", 2000);
      chk("rand_en_cycles", en_highs, exp_en);
      chk("rand_halted", halted_s, m_halted);
      compare_frames("rand");
    end

    chk("wr_rd_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
